truth_table_scanner: RTL and testbench

//   Sequential driver/collector for a combinational N_IN-input boolean function block.
//   On start, steps the input vector 0..2**N_IN-1 into the function, holds each vector SETTLE+1 cycles,
//   and samples the response f into a truth-table register. Also counts minterms.

---
 rtl/tts_pkg.sv | 15 +
 rtl/tts_hold_timer.sv | 27 ++
 rtl/truth_table_scanner.sv | 104 ++++++++++
 tb/tb_truth_table_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table scanner.
package tts_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } tts_state_e;

  localparam int TTS_SETTLE_W = 4;

  function automatic int tts_table_w(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tts_hold_timer.sv
// Per-vector hold timer: loads the settle count, counts down to zero and then parks there.
import tts_pkg::*;

module tts_hold_timer #(
  parameter logic [TTS_SETTLE_W-1:0] SETTLE = 4'd1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_zero
);

  logic [TTS_SETTLE_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= SETTLE;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Steps every input vector into a combinational function, samples its response into a
// truth table and counts the minterms.
import tts_pkg::*;

module truth_table_scanner #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  // Level request, taken on any edge where o_busy is low; ignored while a scan runs.
  input  logic                           i_start,
  output logic [N_IN-1:0]                o_abcd,
  input  logic                           i_f,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [tts_table_w(N_IN)-1:0]   o_table,
  output logic [N_IN:0]                  o_ones,
  output tts_state_e                     o_dbg_state
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  tts_state_e                 r_state;
  tts_state_e                 w_state_nxt;
  logic [N_IN-1:0]            r_abcd;
  logic                       r_busy;
  logic                       r_done;
  logic [tts_table_w(N_IN)-1:0] r_table;
  logic [N_IN:0]              r_ones;

  logic w_zero;
  logic w_accept;
  logic w_sample;
  logic w_last;
  logic w_load;

  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_sample = (r_state == ST_HOLD) && w_zero;
  assign w_last   = (r_abcd == LAST_VEC);
  assign w_load   = w_accept || (w_sample && !w_last);

  tts_hold_timer #(
    .SETTLE (TTS_SETTLE_W'(SETTLE))
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .o_zero (w_zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_HOLD;
      ST_HOLD: if (w_sample && w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_abcd  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_table <= '0;
      r_ones  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy  <= 1'b1;
        r_abcd  <= '0;
        r_table <= '0;
        r_ones  <= '0;
      end else if (w_sample) begin
        r_table[r_abcd] <= i_f;
        r_ones          <= r_ones + (N_IN+1)'(i_f);
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_abcd <= '0;
        end else begin
          r_abcd <= r_abcd + 1'b1;
        end
      end
    end
  end

  assign o_abcd      = r_abcd;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_table     = r_table;
  assign o_ones      = r_ones;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: SETTLE=1 and SETTLE=0 instances, scoreboard on done.
module tb_truth_table_scanner;
  import tts_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start0, start1, f0, f1;
  logic [3:0]  abcd0, abcd1;
  logic        busy0, busy1, done0, done1;
  logic [15:0] table0, table1;
  logic [4:0]  ones0, ones1;
  tts_state_e  st0, st1;
  int          mode;   // 0: reference function, 1: tied 1, 2: tied 0

  function automatic logic ref_fn(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (~a & ~c & ~d) | (~a & b & d) | (~a & ~b & c);
  endfunction

  assign f0 = (mode == 0) ? ref_fn(abcd0) : (mode == 1);
  assign f1 = ref_fn(abcd1);

  truth_table_scanner #(.N_IN(4), .SETTLE(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .o_abcd(abcd0), .i_f(f0),
    .o_busy(busy0), .o_done(done0), .o_table(table0), .o_ones(ones0), .o_dbg_state(st0)
  );

  truth_table_scanner #(.N_IN(4), .SETTLE(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .o_abcd(abcd1), .i_f(f1),
    .o_busy(busy1), .o_done(done1), .o_table(table1), .o_ones(ones1), .o_dbg_state(st1)
  );

  // view of the instance under test
  int          sel;
  logic        s_busy, s_done;
  logic [3:0]  s_abcd;
  logic [15:0] s_table;
  logic [4:0]  s_ones;
  assign s_busy  = (sel != 0) ? busy1  : busy0;
  assign s_done  = (sel != 0) ? done1  : done0;
  assign s_abcd  = (sel != 0) ? abcd1  : abcd0;
  assign s_table = (sel != 0) ? table1 : table0;
  assign s_ones  = (sel != 0) ? ones1  : ones0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt0 = 0, done_cnt1 = 0;
  always @(negedge clk) begin
    if (done0 === 1'b1) done_cnt0++;
    if (done1 === 1'b1) done_cnt1++;
  end

  // scoreboard: {table, ones}
  logic [20:0] exp_q[$];
  int n_pass = 0, n_total = 0;
  int e0;
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver: raise start, record E0; start stays high until drop_start
  task automatic drive_start(input bit push, input logic [20:0] exp_v);
    @(negedge clk);
    if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
    if (push) exp_q.push_back(exp_v);
    @(posedge clk);
    #1;
    e0 = cyc;
    chk("busy_at_e0", s_busy, 1);
  endtask

  task automatic drop_start();
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_vec(input logic [3:0] v);
    int n = 0;
    while (s_abcd !== v && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec", s_abcd, v);
  endtask

  task automatic wait_done(input int lat, input bit check_after);
    int n = 0;
    bit got = 0;
    logic [20:0] v;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (s_done === 1'b1) got = 1;
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("latency", cyc - e0, lat);
      chk("busy_low_at_done", s_busy, 0);
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        v = exp_q.pop_front();
        chk("table", s_table, v[20:5]);
        chk("ones", s_ones, v[4:0]);
        if (check_after) begin
          @(posedge clk);
          #1;
          chk("done_one_cycle", s_done, 0);
          chk("table_held", s_table, v[20:5]);
          chk("ones_held", s_ones, v[4:0]);
          chk("busy_idle", s_busy, 0);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; mode = 0; sel = 0;

    // 1: asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("rst_abcd", abcd0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_table", table0, 0);
    chk("rst_ones", ones0, 0);
    chk("rst_state", 32'(st0), 32'(ST_IDLE));
    chk("rst_table_s0", table1, 0);
    #10;
    @(negedge clk);
    rst = 1'b0;

    // 2: reference function
    drive_start(1, {16'h00BD, 5'd6});
    drop_start();
    wait_done(32, 1);
    chk("single_done", done_cnt0, 1);

    // 3: constant functions
    mode = 1;
    drive_start(1, {16'hFFFF, 5'd16});
    drop_start();
    wait_done(32, 1);
    mode = 2;
    drive_start(1, {16'h0000, 5'd0});
    drop_start();
    wait_done(32, 1);

    // 4: start pulse while busy is ignored
    mode = 0;
    base = done_cnt0;
    drive_start(1, {16'h00BD, 5'd6});
    drop_start();
    wait_vec(4'd7);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("busy_after_pulse", busy0, 1);
    chk("state_after_pulse", 32'(st0), 32'(ST_HOLD));
    wait_done(32, 1);
    chk("done_count_pulse", done_cnt0 - base, 1);

    // 5: reset mid-scan, then a fresh scan
    drive_start(0, '0);
    drop_start();
    wait_vec(4'd5);
    #2 rst = 1'b1;
    #1;
    chk("abort_abcd", abcd0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_table", table0, 0);
    chk("abort_ones", ones0, 0);
    chk("abort_state", 32'(st0), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    drive_start(1, {16'h00BD, 5'd6});
    drop_start();
    wait_done(32, 1);

    // 6: start held high across done -> back-to-back scans
    base = done_cnt0;
    drive_start(1, {16'h00BD, 5'd6});
    exp_q.push_back({16'h00BD, 5'd6});
    wait_done(32, 0);
    @(posedge clk);
    #1;
    e0 = cyc;
    chk("b2b_done_drop", done0, 0);
    chk("b2b_table_clr", table0, 0);
    chk("b2b_ones_clr", ones0, 0);
    chk("b2b_busy", busy0, 1);
    drop_start();
    wait_done(32, 1);
    chk("done_count_b2b", done_cnt0 - base, 2);

    // SETTLE=0 instance
    sel = 1;
    drive_start(1, {16'h00BD, 5'd6});
    drop_start();
    wait_done(16, 1);
    chk("single_done_s0", done_cnt1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
